// File: rtl/row_package_streamer_pkg.sv
// Shared types for the row package streamer:
// widths, FSM states and the buffered package entry.
package row_package_streamer_pkg;

  localparam int NO_OF_UNITS   = 8;
  localparam int ELEMENT_WIDTH = 32;
  localparam int CNT_WIDTH     = 16;
  localparam int PKG_WIDTH     = NO_OF_UNITS * ELEMENT_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic                 first;
    logic                 last;
    logic [CNT_WIDTH-1:0] row_index;
    logic [PKG_WIDTH-1:0] mat;
    logic [PKG_WIDTH-1:0] vec;
  } buf_entry_t;

  localparam int ENTRY_WIDTH = $bits(buf_entry_t);

endpackage

// File: rtl/package_skid_fifo.sv
// Two-entry FIFO that soaks up the read issued
// while the consumer stalls.
module package_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             valid,
  output logic             ready
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_wr;
  logic             do_rd;

  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_rd)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_wr}
                     - {1'b0, do_rd};
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign valid   = ~empty;
  assign ready   = ~full;

endmodule

// File: rtl/row_package_streamer.sv
// Streams matrix-row / vector package pairs with row
// framing to the dot-product unit from two sync memories.
module row_package_streamer
  import row_package_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [CNT_WIDTH-1:0]  cmd_no_of_rows,
  input  logic [CNT_WIDTH-1:0]  cmd_no_of_multiples,
  input  logic [ADDR_WIDTH-1:0] cmd_row_base,
  input  logic [ADDR_WIDTH-1:0] cmd_vec_base,
  output logic                  row_mem_rd_en,
  output logic                  vec_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] row_mem_addr,
  output logic [ADDR_WIDTH-1:0] vec_mem_addr,
  input  logic [PKG_WIDTH-1:0]  row_mem_rdata,
  input  logic [PKG_WIDTH-1:0]  vec_mem_rdata,
  output logic                  pkg_valid,
  input  logic                  pkg_ready,
  output logic [PKG_WIDTH-1:0]  first_row_output,
  output logic [PKG_WIDTH-1:0]  second_row_output,
  output logic                  pkg_first,
  output logic                  pkg_last,
  output logic [CNT_WIDTH-1:0]  row_index,
  output logic [CNT_WIDTH-1:0]  no_of_multiples_out,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  C_ONE = CNT_WIDTH'(1);

  state_e                state;
  logic [ADDR_WIDTH-1:0] row_addr;
  logic [ADDR_WIDTH-1:0] vec_addr;
  logic [ADDR_WIDTH-1:0] vec_base;
  logic [CNT_WIDTH-1:0]  rows;
  logic [CNT_WIDTH-1:0]  mults;
  logic [CNT_WIDTH-1:0]  pkg_idx;
  logic [CNT_WIDTH-1:0]  row_cnt;

  logic                  inflight;
  logic                  tag_first;
  logic                  tag_last;
  logic [CNT_WIDTH-1:0]  tag_row;

  buf_entry_t            wr_entry;
  buf_entry_t            rd_entry;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_valid;
  logic                  fifo_ready;
  logic                  pop;
  logic                  issue;
  logic [1:0]            occ;
  logic [2:0]            used;
  logic                  last_pkg;
  logic                  last_row;

  assign last_pkg = (pkg_idx == mults - C_ONE);
  assign last_row = (row_cnt == rows - C_ONE);
  assign pop      = fifo_valid & pkg_ready;
  assign occ      = {fifo_full, fifo_valid & fifo_ready};
  assign used     = {1'b0, occ} + {2'b0, inflight};

  // The entry leaving this cycle frees a slot, which
  // keeps a full-rate stream free of bubbles.
  assign issue = (state == S_FETCH)
               & (used < 3'd2 + {2'b0, pop});

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      row_addr  <= '0;
      vec_addr  <= '0;
      vec_base  <= '0;
      rows      <= '0;
      mults     <= '0;
      pkg_idx   <= '0;
      row_cnt   <= '0;
      inflight  <= 1'b0;
      tag_first <= 1'b0;
      tag_last  <= 1'b0;
      tag_row   <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        tag_first <= (pkg_idx == '0);
        tag_last  <= last_pkg;
        tag_row   <= row_cnt;
      end
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            rows     <= cmd_no_of_rows;
            mults    <= cmd_no_of_multiples;
            vec_base <= cmd_vec_base;
            row_addr <= cmd_row_base;
            vec_addr <= cmd_vec_base;
            pkg_idx  <= '0;
            row_cnt  <= '0;
            if (cmd_no_of_rows == '0 ||
                cmd_no_of_multiples == '0)
              state <= S_DONE;
            else
              state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (issue) begin
            row_addr <= row_addr + A_ONE;
            if (last_pkg) begin
              vec_addr <= vec_base;
              pkg_idx  <= '0;
              row_cnt  <= row_cnt + C_ONE;
              if (last_row)
                state <= S_DRAIN;
            end else begin
              vec_addr <= vec_addr + A_ONE;
              pkg_idx  <= pkg_idx + C_ONE;
            end
          end
        end
        S_DRAIN: begin
          if (fifo_empty && !inflight)
            state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_entry           = '0;
    wr_entry.first     = tag_first;
    wr_entry.last      = tag_last;
    wr_entry.row_index = tag_row;
    wr_entry.mat       = row_mem_rdata;
    wr_entry.vec       = vec_mem_rdata;
  end

  package_skid_fifo #(
    .WIDTH (ENTRY_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (inflight),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .valid   (fifo_valid),
    .ready   (fifo_ready)
  );

  assign cmd_ready           = (state == S_IDLE);
  assign busy                = (state != S_IDLE);
  assign done                = (state == S_DONE);
  assign row_mem_rd_en       = issue;
  assign vec_mem_rd_en       = issue;
  assign row_mem_addr        = row_addr;
  assign vec_mem_addr        = vec_addr;
  assign no_of_multiples_out = mults;

  assign pkg_valid         = fifo_valid;
  assign first_row_output  = rd_entry.mat;
  assign second_row_output = rd_entry.vec;
  assign pkg_first         = rd_entry.first;
  assign pkg_last          = rd_entry.last;
  assign row_index         = rd_entry.row_index;

endmodule

// File: tb/tb_row_package_streamer.sv
// Scoreboard bench for row_package_streamer with
// address-tagged memory models and ready patterns.
module tb_row_package_streamer;
  import row_package_streamer_pkg::*;

  typedef logic [PKG_WIDTH-1:0] wide_t;

  typedef struct {
    logic [12:0] ma;
    logic [12:0] va;
    logic        first;
    logic        last;
    logic [15:0] row;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_no_of_rows;
  logic [15:0] cmd_no_of_multiples;
  logic [12:0] cmd_row_base;
  logic [12:0] cmd_vec_base;
  logic        row_mem_rd_en;
  logic        vec_mem_rd_en;
  logic [12:0] row_mem_addr;
  logic [12:0] vec_mem_addr;
  wide_t       row_mem_rdata;
  wide_t       vec_mem_rdata;
  logic        pkg_valid;
  logic        pkg_ready;
  wide_t       first_row_output;
  wide_t       second_row_output;
  logic        pkg_first;
  logic        pkg_last;
  logic [15:0] row_index;
  logic [15:0] no_of_multiples_out;
  logic        busy;
  logic        done;

  exp_t q[$];
  int   cyc;
  int   n_chk;
  int   n_pass;
  int   rd_cnt;
  int   hs_cnt;
  int   done_cnt;
  int   done_cyc;
  int   last_hs;
  int   rise_cyc;
  int   t_acc;
  int   rdy_mode;
  logic prev_valid;
  logic prev_stall;

  always #5 clk = ~clk;

  row_package_streamer dut (
    .clk                 (clk),
    .reset               (reset),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_no_of_rows      (cmd_no_of_rows),
    .cmd_no_of_multiples (cmd_no_of_multiples),
    .cmd_row_base        (cmd_row_base),
    .cmd_vec_base        (cmd_vec_base),
    .row_mem_rd_en       (row_mem_rd_en),
    .vec_mem_rd_en       (vec_mem_rd_en),
    .row_mem_addr        (row_mem_addr),
    .vec_mem_addr        (vec_mem_addr),
    .row_mem_rdata       (row_mem_rdata),
    .vec_mem_rdata       (vec_mem_rdata),
    .pkg_valid           (pkg_valid),
    .pkg_ready           (pkg_ready),
    .first_row_output    (first_row_output),
    .second_row_output   (second_row_output),
    .pkg_first           (pkg_first),
    .pkg_last            (pkg_last),
    .row_index           (row_index),
    .no_of_multiples_out (no_of_multiples_out),
    .busy                (busy),
    .done                (done)
  );

  function automatic wide_t mword(
    input logic [12:0] a,
    input logic [7:0]  s
  );
    wide_t w;
    w = '0;
    for (int i = 0; i < NO_OF_UNITS; i++)
      w[i*32 +: 32] = {s, 3'(i), 8'h00, a};
    return w;
  endfunction

  always @(posedge clk) begin
    if (row_mem_rd_en)
      row_mem_rdata <= mword(row_mem_addr, 8'hA5);
    if (vec_mem_rd_en)
      vec_mem_rdata <= mword(vec_mem_addr, 8'h3C);
  end

  task automatic chk(
    input string tag,
    input wide_t got,
    input wide_t exp
  );
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
  endtask

  task automatic monitor();
    exp_t e;
    if (reset) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
      return;
    end
    if (row_mem_rd_en)
      rd_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (pkg_valid && !prev_valid)
      rise_cyc = cyc;
    if (prev_stall)
      chk("hold_valid", wide_t'(pkg_valid), wide_t'(1));
    if (pkg_valid) begin
      if (q.size() == 0) begin
        chk("extra_pkg", wide_t'(0), wide_t'(1));
      end else begin
        e = q[0];
        chk("mat", first_row_output, mword(e.ma, 8'hA5));
        chk("vec", second_row_output, mword(e.va, 8'h3C));
        chk("first", wide_t'(pkg_first), wide_t'(e.first));
        chk("last", wide_t'(pkg_last), wide_t'(e.last));
        chk("row", wide_t'(row_index), wide_t'(e.row));
        if (pkg_ready) begin
          void'(q.pop_front());
          hs_cnt++;
          last_hs = cyc;
        end
      end
    end
    prev_valid = pkg_valid;
    prev_stall = pkg_valid && !pkg_ready;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    case (rdy_mode)
      0:       pkg_ready = 1'b1;
      1:       pkg_ready = ~pkg_ready;
      default: pkg_ready = 1'b0;
    endcase
  endtask

  task automatic run_cmd(
    input int          rows,
    input int          mult,
    input logic [12:0] rb,
    input logic [12:0] vb
  );
    exp_t e;
    chk("cmd_ready", wide_t'(cmd_ready), wide_t'(1));
    cmd_valid           = 1'b1;
    cmd_no_of_rows      = 16'(rows);
    cmd_no_of_multiples = 16'(mult);
    cmd_row_base        = rb;
    cmd_vec_base        = vb;
    for (int r = 0; r < rows; r++)
      for (int p = 0; p < mult; p++) begin
        e.ma    = 13'(int'(rb) + r * mult + p);
        e.va    = 13'(int'(vb) + p);
        e.first = (p == 0);
        e.last  = (p == mult - 1);
        e.row   = 16'(r);
        q.push_back(e);
      end
    t_acc = cyc;
    tick();
    cmd_valid = 1'b0;
    chk("nmo", wide_t'(no_of_multiples_out), wide_t'(mult));
    chk("busy", wide_t'(busy), wide_t'(1));
  endtask

  task automatic wait_done(input int limit);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < limit) begin
      tick();
      k++;
    end
    chk("done_seen", wide_t'(done_cnt != d0), wide_t'(1));
  endtask

  initial begin
    int h0;
    int r0;
    int k;
    int d;
    reset               = 1'b1;
    cmd_valid           = 1'b0;
    cmd_no_of_rows      = '0;
    cmd_no_of_multiples = '0;
    cmd_row_base        = '0;
    cmd_vec_base        = '0;
    pkg_ready           = 1'b0;
    rdy_mode            = 0;
    cyc = 0; n_chk = 0; n_pass = 0; rd_cnt = 0;
    hs_cnt = 0; done_cnt = 0; done_cyc = 0;
    last_hs = 0; rise_cyc = 0; t_acc = 0;
    prev_valid = 1'b0;
    prev_stall = 1'b0;

    repeat (3) tick();
    chk("rst_cmd_ready", wide_t'(cmd_ready), wide_t'(1));
    chk("rst_rd_en", wide_t'(row_mem_rd_en), wide_t'(0));
    chk("rst_row_addr", wide_t'(row_mem_addr), wide_t'(0));
    chk("rst_vec_addr", wide_t'(vec_mem_addr), wide_t'(0));
    chk("rst_valid", wide_t'(pkg_valid), wide_t'(0));
    chk("rst_first", wide_t'(pkg_first), wide_t'(0));
    chk("rst_last", wide_t'(pkg_last), wide_t'(0));
    chk("rst_row", wide_t'(row_index), wide_t'(0));
    chk("rst_nmo", wide_t'(no_of_multiples_out), wide_t'(0));
    chk("rst_busy", wide_t'(busy), wide_t'(0));
    chk("rst_done", wide_t'(done), wide_t'(0));
    reset = 1'b0;
    tick();

    // 3x4 at full rate
    h0 = hs_cnt;
    run_cmd(3, 4, 13'h010, 13'h100);
    wait_done(40);
    chk("t1_first_valid", wide_t'(rise_cyc - t_acc), wide_t'(3));
    chk("t1_last_hs", wide_t'(last_hs - t_acc), wide_t'(14));
    chk("t1_done", wide_t'(done_cyc - t_acc), wide_t'(16));
    chk("t1_count", wide_t'(hs_cnt - h0), wide_t'(12));
    chk("t1_q_empty", wide_t'(q.size()), wide_t'(0));

    // toggling ready
    rdy_mode = 1;
    h0 = hs_cnt;
    run_cmd(3, 4, 13'h010, 13'h100);
    wait_done(80);
    chk("t2_count", wide_t'(hs_cnt - h0), wide_t'(12));
    chk("t2_q_empty", wide_t'(q.size()), wide_t'(0));

    // long stall after first valid
    rdy_mode = 2;
    tick();
    h0 = hs_cnt;
    r0 = rd_cnt;
    run_cmd(3, 4, 13'h010, 13'h100);
    k = 0;
    while (!pkg_valid && k < 10) begin
      tick();
      k++;
    end
    chk("t3_valid_up", wide_t'(pkg_valid), wide_t'(1));
    repeat (10) tick();
    chk("t3_reads", wide_t'(rd_cnt - r0), wide_t'(2));
    chk("t3_no_hs", wide_t'(hs_cnt - h0), wide_t'(0));
    chk("t3_valid_held", wide_t'(pkg_valid), wide_t'(1));
    rdy_mode = 0;
    wait_done(60);
    chk("t3_count", wide_t'(hs_cnt - h0), wide_t'(12));
    chk("t3_q_empty", wide_t'(q.size()), wide_t'(0));

    // empty commands
    h0 = hs_cnt;
    run_cmd(0, 4, 13'h020, 13'h120);
    wait_done(10);
    d = done_cyc - t_acc;
    chk("t4_done_lat", wide_t'(d >= 1 && d <= 2), wide_t'(1));
    run_cmd(2, 0, 13'h020, 13'h120);
    wait_done(10);
    d = done_cyc - t_acc;
    chk("t4b_done_lat", wide_t'(d >= 1 && d <= 2), wide_t'(1));
    chk("t4_count", wide_t'(hs_cnt - h0), wide_t'(0));

    // single package row
    h0 = hs_cnt;
    run_cmd(1, 1, 13'h055, 13'h155);
    wait_done(20);
    chk("t5_count", wide_t'(hs_cnt - h0), wide_t'(1));
    chk("t5_q_empty", wide_t'(q.size()), wide_t'(0));

    // reset at the fifth package
    h0 = hs_cnt;
    run_cmd(3, 4, 13'h010, 13'h100);
    k = 0;
    while (hs_cnt - h0 < 4 && k < 30) begin
      tick();
      k++;
    end
    chk("t6_reach5", wide_t'(hs_cnt - h0), wide_t'(4));
    chk("t6_valid5", wide_t'(pkg_valid), wide_t'(1));
    reset = 1'b1;
    tick();
    chk("t6_idle", wide_t'(cmd_ready), wide_t'(1));
    chk("t6_busy", wide_t'(busy), wide_t'(0));
    chk("t6_valid", wide_t'(pkg_valid), wide_t'(0));
    chk("t6_rd_en", wide_t'(row_mem_rd_en), wide_t'(0));
    chk("t6_addr", wide_t'(row_mem_addr), wide_t'(0));
    reset = 1'b0;
    q.delete();
    h0 = hs_cnt;
    run_cmd(1, 2, 13'h040, 13'h200);
    wait_done(20);
    chk("t6_count", wide_t'(hs_cnt - h0), wide_t'(2));
    chk("t6_q_empty", wide_t'(q.size()), wide_t'(0));

    // address wrap
    h0 = hs_cnt;
    run_cmd(1, 4, 13'h1FFE, 13'h0F0);
    wait_done(20);
    chk("t7_count", wide_t'(hs_cnt - h0), wide_t'(4));
    chk("t7_q_empty", wide_t'(q.size()), wide_t'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
